// File: rtl/conv3x3_pkg.sv
// Shared constants and helpers for the 3x3 convolution engine: tap count,
// default Gaussian kernel, datapath width functions and the unsigned clip.
package conv3x3_pkg;

  localparam int NTAPS = 9;

  // Row-major default kernel; sums to 16 so NORM_SHIFT=4 gives unity gain.
  localparam int DEF_KERNEL [NTAPS] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

  function automatic int prod_w(input int data_w, input int coef_w);
    return data_w + coef_w + 1;
  endfunction

  function automatic int sum_w(input int data_w, input int coef_w);
    return prod_w(data_w, coef_w) + 4;
  endfunction

  typedef struct packed {
    logic        sat;
    logic [31:0] val;
  } clip_t;

  function automatic clip_t clip_u(input logic signed [63:0] v, input int data_w);
    clip_t             r;
    logic signed [63:0] maxv;
    maxv  = (64'sd1 <<< data_w) - 64'sd1;
    r.sat = 1'b0;
    r.val = 32'(v);
    if (v < 64'sd0) begin
      r.sat = 1'b1;
      r.val = '0;
    end else if (v > maxv) begin
      r.sat = 1'b1;
      r.val = 32'(maxv);
    end
    return r;
  endfunction

endpackage

// File: rtl/conv3x3_coef_bank.sv
// Shadow/active coefficient banks with frame-safe commit: a requested commit
// waits until the frame boundary (or an idle, out-of-frame cycle) to swap.
module conv3x3_coef_bank
  import conv3x3_pkg::*;
#(
  parameter int COEF_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    coef_we_i,
  input  logic [3:0]              coef_addr_i,
  input  logic [COEF_W-1:0]       coef_data_i,
  input  logic                    coef_commit_i,
  input  logic                    beat_acc_i,
  input  logic                    beat_last_i,
  output logic [NTAPS*COEF_W-1:0] active_o,
  output logic                    cfg_pending_o
);

  logic [COEF_W-1:0] shadow_q [NTAPS];
  logic [COEF_W-1:0] shadow_d [NTAPS];
  logic [COEF_W-1:0] active_q [NTAPS];
  logic [COEF_W-1:0] active_d [NTAPS];
  logic              in_frame_q, in_frame_d;
  logic              pending_q, pending_d;
  logic              pend_req;
  logic              apply;

  always_comb begin
    shadow_d = shadow_q;
    if (coef_we_i && (coef_addr_i <= 4'd8)) begin
      shadow_d[coef_addr_i] = coef_data_i;
    end

    // A commit arriving in the same cycle as the apply condition takes effect
    // at once, and the copy sees any shadow write made in that cycle.
    pend_req = pending_q | coef_commit_i;
    apply    = pend_req & ((beat_acc_i & beat_last_i) | (~in_frame_q & ~beat_acc_i));

    active_d   = apply ? shadow_d : active_q;
    pending_d  = pend_req & ~apply;
    in_frame_d = beat_acc_i ? ~beat_last_i : in_frame_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= COEF_W'(DEF_KERNEL[k]);
        active_q[k] <= COEF_W'(DEF_KERNEL[k]);
      end
      in_frame_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      in_frame_q <= in_frame_d;
      pending_q  <= pending_d;
    end
  end

  for (genvar k = 0; k < NTAPS; k++) begin : g_flat
    assign active_o[k*COEF_W +: COEF_W] = active_q[k];
  end

  assign cfg_pending_o = pending_q;

endmodule

// File: rtl/conv3x3_stream.sv
// Three-stage (multiply, adder tree, normalise/clip) 3x3 convolution with a
// common stall enable. Define CONV_ROUND_EN for round-half-up normalisation.
module conv3x3_stream
  import conv3x3_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int COEF_W     = 8,
  parameter int NORM_SHIFT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [9*DATA_W-1:0]   i_pixel_data,
  input  logic                  i_pixel_data_valid,
  input  logic                  i_pixel_data_last,
  output logic                  o_pixel_data_ready,
  output logic [DATA_W-1:0]     o_convolved_data,
  output logic                  o_convolved_data_valid,
  output logic                  o_convolved_data_last,
  output logic                  o_convolved_sat,
  input  logic                  i_out_ready,
  input  logic                  i_coef_we,
  input  logic [3:0]            i_coef_addr,
  input  logic [COEF_W-1:0]     i_coef_data,
  input  logic                  i_coef_commit,
  output logic                  o_cfg_pending
);

  localparam int PROD_W = prod_w(DATA_W, COEF_W);
  localparam int SUM_W  = sum_w(DATA_W, COEF_W);

  logic                      en;
  logic                      acc;
  logic [NTAPS*COEF_W-1:0]   coef_flat;

  logic signed [PROD_W-1:0]  prod_d [NTAPS];
  logic signed [PROD_W-1:0]  prod_q [NTAPS];
  logic                      v1_q, l1_q;

  logic signed [SUM_W-1:0]   sum_d, sum_q;
  logic                      v2_q, l2_q;

  logic signed [SUM_W-1:0]   rounded;
  logic signed [SUM_W-1:0]   norm;
  clip_t                     clip_r;

  logic [DATA_W-1:0]         data_q;
  logic                      valid_q, last_q, sat_q;

  assign en                 = ~valid_q | i_out_ready;
  assign acc                = i_pixel_data_valid & en;
  assign o_pixel_data_ready = en;

  conv3x3_coef_bank #(
    .COEF_W (COEF_W)
  ) u_coef_bank (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .coef_we_i     (i_coef_we),
    .coef_addr_i   (i_coef_addr),
    .coef_data_i   (i_coef_data),
    .coef_commit_i (i_coef_commit),
    .beat_acc_i    (acc),
    .beat_last_i   (i_pixel_data_last),
    .active_o      (coef_flat),
    .cfg_pending_o (o_cfg_pending)
  );

  // Pixels are unsigned: a leading zero makes them non-negative signed operands.
  always_comb begin
    for (int k = 0; k < NTAPS; k++) begin
      prod_d[k] = PROD_W'($signed({1'b0, i_pixel_data[k*DATA_W +: DATA_W]}))
                * PROD_W'($signed(coef_flat[k*COEF_W +: COEF_W]));
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NTAPS; k++) begin
      sum_d = sum_d + SUM_W'(prod_q[k]);
    end
  end

  always_comb begin
`ifdef CONV_ROUND_EN
    rounded = sum_q + SUM_W'((2 ** NORM_SHIFT) / 2);
`else
    rounded = sum_q;
`endif
    norm   = rounded >>> NORM_SHIFT;
    clip_r = clip_u(64'(norm), DATA_W);
  end

  if (DATA_W < 32) begin : g_clip_hi
    logic unused_clip_hi;
    assign unused_clip_hi = ^clip_r.val[31:DATA_W];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        prod_q[k] <= '0;
      end
      v1_q    <= 1'b0;
      l1_q    <= 1'b0;
      sum_q   <= '0;
      v2_q    <= 1'b0;
      l2_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else if (en) begin
      prod_q  <= prod_d;
      v1_q    <= acc;
      l1_q    <= acc & i_pixel_data_last;
      sum_q   <= sum_d;
      v2_q    <= v1_q;
      l2_q    <= l1_q;
      data_q  <= clip_r.val[DATA_W-1:0];
      valid_q <= v2_q;
      last_q  <= l2_q;
      sat_q   <= v2_q & clip_r.sat;
    end
  end

  assign o_convolved_data       = data_q;
  assign o_convolved_data_valid = valid_q;
  assign o_convolved_data_last  = last_q;
  assign o_convolved_sat        = sat_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream: stimulus pushes expected beats at
// acceptance, a negedge monitor pops and compares when the output is taken.
module tb_conv3x3_stream;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            i_rst;
  logic [9*DW-1:0] i_pixel_data;
  logic            i_pixel_data_valid;
  logic            i_pixel_data_last;
  logic            o_pixel_data_ready;
  logic [DW-1:0]   o_convolved_data;
  logic            o_convolved_data_valid;
  logic            o_convolved_data_last;
  logic            o_convolved_sat;
  logic            i_out_ready;
  logic            i_coef_we;
  logic [3:0]      i_coef_addr;
  logic [CW-1:0]   i_coef_data;
  logic            i_coef_commit;
  logic            o_cfg_pending;

  conv3x3_stream #(.DATA_W(DW), .COEF_W(CW), .NORM_SHIFT(NS)) dut (
    .i_clk                  (clk),
    .i_rst                  (i_rst),
    .i_pixel_data           (i_pixel_data),
    .i_pixel_data_valid     (i_pixel_data_valid),
    .i_pixel_data_last      (i_pixel_data_last),
    .o_pixel_data_ready     (o_pixel_data_ready),
    .o_convolved_data       (o_convolved_data),
    .o_convolved_data_valid (o_convolved_data_valid),
    .o_convolved_data_last  (o_convolved_data_last),
    .o_convolved_sat        (o_convolved_sat),
    .i_out_ready            (i_out_ready),
    .i_coef_we              (i_coef_we),
    .i_coef_addr            (i_coef_addr),
    .i_coef_data            (i_coef_data),
    .i_coef_commit          (i_coef_commit),
    .o_cfg_pending          (o_cfg_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit last;
    bit sat;
    bit chk;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  int   drv_data;
  bit   drv_sat;
  bit   drv_chk;

  bit            stall_prev = 0;
  logic [DW-1:0] hold_data;
  logic          hold_last, hold_sat;

  int GAUSS [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model(input int t[9], input int k[9], output int d, output bit s);
    int sum, sh;
    sum = 0;
    for (int i = 0; i < 9; i++) sum += t[i] * k[i];
`ifdef CONV_ROUND_EN
    sum += (1 << NS) / 2;
`endif
    sh = sum >>> NS;
    if (sh < 0) begin d = 0; s = 1; end
    else if (sh > 255) begin d = 255; s = 1; end
    else begin d = sh; s = 0; end
  endfunction

  // Monitor and scoreboard push, both evaluated away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (i_rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_hold", int'(o_convolved_data_valid), 1);
        check("stall_data_hold", int'(o_convolved_data), int'(hold_data));
        check("stall_last_hold", int'(o_convolved_data_last), int'(hold_last));
        check("stall_sat_hold", int'(o_convolved_sat), int'(hold_sat));
      end
      if (o_convolved_data_valid && !i_out_ready)
        check("ready_low_in_stall", int'(o_pixel_data_ready), 0);
      if (o_convolved_data_valid && i_out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_data", int'(o_convolved_data), e.data);
          check("out_last", int'(o_convolved_data_last), int'(e.last));
          check("out_sat", int'(o_convolved_sat), int'(e.sat));
          if (e.chk) check("latency", cyc - e.cyc, 3);
        end
      end
      if (i_pixel_data_valid && o_pixel_data_ready) begin
        e.data = drv_data; e.last = i_pixel_data_last; e.sat = drv_sat;
        e.chk = drv_chk; e.cyc = cyc;
        sb.push_back(e);
      end
      stall_prev = o_convolved_data_valid && !i_out_ready;
      hold_data  = o_convolved_data;
      hold_last  = o_convolved_data_last;
      hold_sat   = o_convolved_sat;
    end
  end

  // All tasks start and end at posedge+1.
  task automatic send(input int t[9], input bit last, input int ed, input bit es, input bit chk);
    bit ok;
    for (int k = 0; k < 9; k++) i_pixel_data[k*DW +: DW] = 8'(t[k]);
    i_pixel_data_last  = last;
    drv_data = ed; drv_sat = es; drv_chk = chk;
    i_pixel_data_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (o_pixel_data_ready) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    i_pixel_data_valid = 1'b0;
    i_pixel_data_last  = 1'b0;
  endtask

  task automatic send_model(input int t[9], input int k[9], input bit last, input bit chk);
    int d; bit s;
    model(t, k, d, s);
    send(t, last, d, s, chk);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic wr_coef(input int a, input int v);
    i_coef_we = 1'b1; i_coef_addr = 4'(a); i_coef_data = 8'(v);
    @(posedge clk); #1;
    i_coef_we = 1'b0;
  endtask

  task automatic commit();
    i_coef_commit = 1'b1;
    @(posedge clk); #1;
    i_coef_commit = 1'b0;
  endtask

  // Writes taps 0..7, then tap 8 together with the commit strobe.
  task automatic load_commit(input int k[9]);
    for (int i = 0; i < 8; i++) wr_coef(i, k[i]);
    wr_coef(12, 99);
    i_coef_we = 1'b1; i_coef_addr = 4'd8; i_coef_data = 8'(k[8]);
    i_coef_commit = 1'b1;
    @(posedge clk); #1;
    i_coef_we = 1'b0; i_coef_commit = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t[9], k[9], id[9];
    int tog;
    bit bp_done;
    i_rst = 1'b1; i_pixel_data = '0; i_pixel_data_valid = 1'b0; i_pixel_data_last = 1'b0;
    i_out_ready = 1'b1; i_coef_we = 1'b0; i_coef_addr = '0; i_coef_data = '0; i_coef_commit = 1'b0;
    drv_data = 0; drv_sat = 0; drv_chk = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(o_convolved_data_valid), 0);
    check("rst_data", int'(o_convolved_data), 0);
    check("rst_last", int'(o_convolved_data_last), 0);
    check("rst_sat", int'(o_convolved_sat), 0);
    check("rst_pending", int'(o_cfg_pending), 0);
    check("rst_ready", int'(o_pixel_data_ready), 1);
    @(posedge clk); #1;
    i_rst = 1'b0;

    // Default kernel, hand-computed results
    t = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    send(t, 0, 100, 0, 1);
    t = '{0, 10, 20, 30, 40, 50, 60, 70, 80};
    send(t, 0, 40, 0, 1);
    t = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    send(t, 1, 255, 0, 1);
    drain();

    // Kernel all 15: overflow clip
    k = '{15, 15, 15, 15, 15, 15, 15, 15, 15};
    load_commit(k);
    check("idle_commit_pending", int'(o_cfg_pending), 0);
    send(t, 1, 255, 1, 1);
    drain();

    // Sharpen kernel: negative clip, exact positive
    k = '{-4, -4, -4, -4, 16, -4, -4, -4, -4};
    load_commit(k);
    t = '{200, 200, 200, 200, 0, 200, 200, 200, 200};
    send(t, 0, 0, 1, 1);
    t = '{10, 10, 10, 10, 10, 10, 10, 10, 10};
    send(t, 0, 0, 1, 1);
    t = '{0, 0, 0, 0, 100, 0, 0, 0, 0};
    send(t, 1, 100, 0, 1);
    drain();

    // Backpressure stream with the default kernel
    load_commit(GAUSS);
    bp_done = 0;
    tog = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          for (int j = 0; j < 9; j++) t[j] = (i * 37 + j * 29) % 256;
          send_model(t, GAUSS, (i == 19), 0);
        end
        bp_done = 1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk); #1;
          tog++;
          if (tog % 2 == 0) i_out_ready = ~i_out_ready;
        end
      end
    join
    i_out_ready = 1'b1;
    drain();

    // Rounding with the default kernel
    t = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    send(t, 0, 1, 0, 1);
    t = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    send(t, 0, 0, 0, 1);
    t = '{0, 0, 0, 0, 2, 0, 0, 0, 0};
`ifdef CONV_ROUND_EN
    send(t, 1, 1, 0, 1);
`else
    send(t, 1, 0, 0, 1);
`endif
    drain();

    // Commit mid-frame: identity must wait until the frame's last beat
    t = '{12, 34, 56, 78, 90, 21, 43, 65, 87};
    send_model(t, GAUSS, 0, 1);
    id = '{0, 0, 0, 0, 16, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) wr_coef(i, id[i]);
    commit();
    check("pending_after_commit", int'(o_cfg_pending), 1);
    t = '{200, 10, 200, 10, 5, 10, 200, 10, 200};
    send_model(t, GAUSS, 0, 1);
    check("pending_mid_frame", int'(o_cfg_pending), 1);
    t = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    send_model(t, GAUSS, 1, 1);
    check("pending_after_last", int'(o_cfg_pending), 0);
    t = '{250, 250, 250, 250, 77, 250, 250, 250, 250};
    send(t, 1, 77, 0, 1);
    drain();

    // Reset mid-frame: pipeline flushed, pending dropped, banks restored
    t = '{1, 2, 3, 4, 50, 6, 7, 8, 9};
    send(t, 0, 50, 0, 1);
    drain();
    wr_coef(0, 7);
    commit();
    check("pending_in_frame", int'(o_cfg_pending), 1);
    t = '{99, 99, 99, 99, 99, 99, 99, 99, 99};
    send(t, 0, 99, 0, 1);
    i_rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_pending", int'(o_cfg_pending), 0);
    check("midrst_valid", int'(o_convolved_data_valid), 0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("flush_no_output", sb.size(), 0);
    commit();
    check("post_rst_commit_pending", int'(o_cfg_pending), 0);
    t = '{0, 0, 0, 0, 100, 0, 0, 0, 0};
    send(t, 0, 25, 0, 1);
    t = '{30, 60, 90, 120, 150, 180, 210, 240, 15};
    send_model(t, GAUSS, 1, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Parametrised 3x3 convolution engine, successor to the fixed-Gaussian convolver. Sits between the line-buffer window generator and the output stream packer.
- Consumes one 3x3 window per accepted beat; emits one filtered pixel.
- Adds generic pixel width, runtime-loadable signed coefficients with frame-safe commit, full valid/ready handshake with upstream ready, and rounding/saturation.

Parameters:
- DATA_W, 8, pixel width in bits, unsigned.
- COEF_W, 8, coefficient width in bits, signed two's complement.
- NORM_SHIFT, 4, arithmetic right shift applied to the sum; range 0..15.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_pixel_data  in  9*DATA_W  window; tap k occupies bits [k*DATA_W +: DATA_W], k=0 top-left, row-major.
- i_pixel_data_valid  in  1  input beat valid
- i_pixel_data_last  in  1  last beat of frame
- o_pixel_data_ready  out  1  block accepts input this cycle
- o_convolved_data  out  DATA_W  filtered pixel
- o_convolved_data_valid  out  1  output beat valid
- o_convolved_data_last  out  1  end of frame, aligned with its beat
- o_convolved_sat  out  1  this output beat was clipped
- i_out_ready  in  1  downstream accepts output
- i_coef_we  in  1  shadow coefficient write strobe
- i_coef_addr  in  4  tap index 0..8; values 9..15 ignored
- i_coef_data  in  COEF_W  signed coefficient
- i_coef_commit  in  1  request shadow->active copy
- o_cfg_pending  out  1  commit requested but not yet applied

Behaviour:
- Reset: all valid, last, sat and data outputs 0; o_cfg_pending 0; in_frame 0. Shadow and active banks = 1,2,1,2,4,2,1,2,1.
- Pipeline has 3 registered stages: multiply, adder tree, normalise/clip. Common enable: en = !o_convolved_data_valid | i_out_ready.
- o_pixel_data_ready = en. The upstream beat is accepted when valid & ready.
- Bubbles propagate as valid=0. Latency is exactly 3 cycles from acceptance to output with no stall.
- When en=0, every stage holds. Output data/valid/last/sat stay stable until accepted, so no beat is lost or duplicated.
- Multiply: zero-extend each tap to DATA_W+1, multiply signed by the active coefficient. PROD_W = DATA_W+COEF_W+1.
- Sum: full-precision signed add of 9 products. SUM_W = PROD_W+4, so no overflow is possible.
- Normalise: arithmetic shift right by NORM_SHIFT (truncation toward minus infinity unless CONV_ROUND_EN is defined).
- Clip: result <0 gives 0; result >2^DATA_W-1 gives 2^DATA_W-1. o_convolved_sat=1 for that beat when either clip occurs.
- Coefficient writes: i_coef_we with addr<=8 updates that shadow entry at the edge. Writes never disturb active coefficients.
- in_frame: set on any accepted beat, cleared on an accepted beat with last=1.
- Commit: i_coef_commit sets pending. Active<=shadow on the first edge where pending=1 and either:
  - an accepted beat has last=1 (that beat still uses the old bank); or
  - in_frame=0 and no beat is accepted.
- pending clears on that same edge. Commit while pending=1 is idempotent.
- Commit and apply condition in the same cycle: applies immediately and pending stays 0.
- Commit and a shadow write in the same cycle: the copied value includes the write.
- Reset mid-frame: the pipeline is flushed with no output, pending is dropped, and both banks return to the default Gaussian.

Optional Feature:
- CONV_ROUND_EN
  - Defined: add 2^(NORM_SHIFT-1) before the shift (no add when NORM_SHIFT=0), giving round-half-up. Clipping is applied after rounding.
  - Undefined: plain truncating arithmetic shift. Latency is unchanged either way.

Decomposition:
- Package conv3x3_pkg:
  - default kernel constant array;
  - width functions PROD_W and SUM_W;
  - tap count 9;
  - clip helper function.
- Sub-module conv3x3_coef_bank: shadow/active registers, in_frame and pending logic, commit rule. Exports the flat active-coefficient vector.

Test Plan:
- Default kernel, all taps 100, i_out_ready=1 -> output 100 (sum 1600>>4) exactly 3 cycles after acceptance; last propagates aligned.
- All taps 255 with kernel all 15 -> sum 34425, >>4 = 2151 -> output 255, sat=1.
- Kernel centre 16, others -4, centre tap 0, neighbours 200 -> sum -6400 -> output 0, sat=1.
- Backpressure: stream 20 beats while i_out_ready toggles every 2 cycles. Check:
  - every input appears once, in order, with a scoreboard match;
  - o_pixel_data_ready low whenever the output is stalled;
  - output holds stable during the stall.
- Commit mid-frame, kernel changed to identity (centre 16):
  - beats up to and including last use the Gaussian;
  - first beat of the next frame equals its centre tap;
  - o_cfg_pending is 1 until the last edge.
- Rounding: all taps 1 with the default kernel gives sum 16, output 1. Centre tap 1, rest 0 gives sum 4: output 0 when undefined, 0 when defined (4+8=12>>4). Centre tap 2 gives sum 8: output 0 when undefined, 1 when defined.
